// File: rtl/seg_scan_if.sv
// seg_scan_if -- bundle between a 7-segment scan controller and its user,
// the shared 4-bit-to-7-seg decoder and the display pins.
//
// Signals:
//   load      user -> ctrl   request to latch value_in
//   value_in  user -> ctrl   nibble i = digit i, digit 0 least significant
//   lzb_en    user -> ctrl   leading-zero blanking enable
//   ready     ctrl -> user   no update pending, load will be accepted
//   bin_out   ctrl -> dec    nibble presented to the shared decoder
//   seg_in    dec  -> ctrl   decoder segment pattern
//   seg       ctrl -> pins   registered segment pattern
//   an        ctrl -> pins   digit anodes, active low
//
// Handshake: a load is accepted on a rising clk edge where load=1 and
// ready=1; ready drops on the following cycle and stays low until the
// accepted value has been moved to the display at a frame boundary.
// load while ready=0 is ignored and never overwrites the pending value.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    lzb_en;
    logic                    ready;
    logic [3:0]              bin_out;
    logic [6:0]              seg_in;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
        output load, value_in, lzb_en, seg_in,
        input  ready, bin_out, seg, an
    );

    modport slave (
        input  load, value_in, lzb_en, seg_in,
        output ready, bin_out, seg, an
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- time-multiplexed scan controller for a bank of 7-segment
// digits sharing one combinational decoder. Each digit gets a slot of
// REFRESH_DIV cycles: the first BLANK_CYCLES with every anode off (ghosting
// guard), the rest with that digit's anode driven low. Display values are
// double buffered: a load lands in a pending register and is copied to the
// active register only on the last cycle of the last digit, so a frame is
// never drawn with mixed old/new data.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous reset, active low
//   bus          seg_scan_if slave modport (load/ready handshake, decoder
//                nibble and pattern, seg and an display outputs)
//   dbg_state_o  current FSM state (0 = blank gap, 1 = digit shown)
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    seg_scan_if.slave bus,
    output logic     dbg_state_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        digit_idx_q;
    logic [CNT_W-1:0]        slot_cnt_q;
    logic [4*NUM_DIGITS-1:0] active_q;
    logic [4*NUM_DIGITS-1:0] pending_q;
    logic                    pend_flag_q;
    logic                    ready_q;
    logic [6:0]              seg_q;

    logic                    slot_end;
    logic                    frame_end;
    logic                    load_acc;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   an_c;

    assign slot_end  = (state_q == ST_SHOW) && (slot_cnt_q == SLOT_LAST);
    assign frame_end = slot_end && (digit_idx_q == IDX_LAST);
    assign load_acc  = bus.load && ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BLANK;
            digit_idx_q <= '0;
            slot_cnt_q  <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_flag_q <= 1'b0;
            ready_q     <= 1'b1;
            seg_q       <= 7'h7F;
        end else begin
            // Decoder output is captured every cycle; bin_out is constant
            // over a slot, so seg settles during the blank gap.
            seg_q <= bus.seg_in;

            case (state_q)
                ST_BLANK: begin
                    slot_cnt_q <= slot_cnt_q + 1'b1;
                    if (slot_cnt_q == BLANK_LAST) begin
                        state_q <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (slot_end) begin
                        state_q     <= ST_BLANK;
                        slot_cnt_q  <= '0;
                        digit_idx_q <= (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
                    end else begin
                        slot_cnt_q <= slot_cnt_q + 1'b1;
                    end
                end
            endcase

            // Frame-boundary copy comes first so that a load accepted on
            // the same edge overrides the flag/ready update while the copy
            // still takes the old pending value.
            if (frame_end && pend_flag_q) begin
                active_q    <= pending_q;
                pend_flag_q <= 1'b0;
                ready_q     <= 1'b1;
            end
            if (load_acc) begin
                pending_q   <= bus.value_in;
                pend_flag_q <= 1'b1;
                ready_q     <= 1'b0;
            end
        end
    end

    // lz_blank[i] = 1 when active nibbles i..NUM_DIGITS-1 are all zero.
    // Digit 0 is never blanked.
    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run & (active_q[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_run;
        end
    end

    always_comb begin
        an_c = '1;
        if ((state_q == ST_SHOW) && !(bus.lzb_en && lz_blank[digit_idx_q])) begin
            an_c[digit_idx_q] = 1'b0;
        end
    end

    assign bus.an      = an_c;
    assign bus.bin_out = active_q[{digit_idx_q, 2'b00} +: 4];
    assign bus.seg     = seg_q;
    assign bus.ready   = ready_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl -- randomized bench for seg_scan_ctrl (4 digits, 8-cycle
// slots, 2 blank cycles). The expected display is derived from elapsed
// cycles since reset (slot = t/8, digit = slot%4, gap when t%8 < 2) and a
// small double-buffer model; a monitor compares every cycle on the falling
// edge.
module tb_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * RD;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    logic dbg_state;

    seg_scan_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- shared decoder stand-in ----------------
    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'h0: dec7 = 7'h40;  4'h1: dec7 = 7'h79;  4'h2: dec7 = 7'h24;  4'h3: dec7 = 7'h30;
            4'h4: dec7 = 7'h19;  4'h5: dec7 = 7'h12;  4'h6: dec7 = 7'h02;  4'h7: dec7 = 7'h78;
            4'h8: dec7 = 7'h00;  4'h9: dec7 = 7'h10;  4'hA: dec7 = 7'h08;  4'hB: dec7 = 7'h03;
            4'hC: dec7 = 7'h46;  4'hD: dec7 = 7'h21;  4'hE: dec7 = 7'h06;  default: dec7 = 7'h0E;
        endcase
    endfunction

    assign bus.seg_in = dec7(bus.bin_out);

    // ---------------- reference model ----------------
    int          m_t;
    logic [15:0] m_active;
    logic [15:0] m_pending;
    logic        m_flag;
    logic        m_ready;
    logic [6:0]  m_seg;

    function automatic logic [3:0] m_nibble(input logic [15:0] val, input int d);
        logic [15:0] sh;
        sh = val >> (4 * d);
        return sh[3:0];
    endfunction

    task automatic model_reset();
        m_t       = 0;
        m_active  = '0;
        m_pending = '0;
        m_flag    = 1'b0;
        m_ready   = 1'b1;
        m_seg     = 7'h7F;
    endtask

    // One rising edge with the inputs that were applied before it.
    task automatic model_step();
        int   digit;
        logic acc;
        digit = (m_t / RD) % ND;
        acc   = bus.load && m_ready;
        m_seg = dec7(m_nibble(m_active, digit));
        if ((m_t % FRAME) == FRAME - 1 && m_flag) begin
            m_active = m_pending;
            m_flag   = 1'b0;
            m_ready  = 1'b1;
        end
        if (acc) begin
            m_pending = bus.value_in;
            m_flag    = 1'b1;
            m_ready   = 1'b0;
        end
        m_t++;
    endtask

    function automatic logic [W-1:0] model_exp();
        int          digit;
        int          phase;
        logic [3:0]  an;
        logic [15:0] upper;
        digit = (m_t / RD) % ND;
        phase = m_t % RD;
        upper = m_active >> (4 * digit);
        an    = 4'hF;
        if (phase >= BC && !(bus.lzb_en && digit > 0 && upper == 16'h0)) begin
            an = ~(4'b0001 << digit);
        end
        return {an, m_nibble(m_active, digit), m_ready, m_seg};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_compared;
    int n_mismatched;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("an",      16'(bus.an),      16'(e[15:12]));
            chk("bin_out", 16'(bus.bin_out), 16'(e[11:8]));
            chk("ready",   16'(bus.ready),   16'(e[7]));
            chk("seg",     16'(bus.seg),     16'(e[6:0]));
            n_compared++;
            if ($countones(~bus.an) > 1) begin
                n_mismatched++;
                $display("FAIL an_onehot at %0t: got %h expected at most one low bit", $time, bus.an);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic ld, input logic [15:0] v, input logic lz, input logic rn);
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        bus.load     = ld;
        bus.value_in = v;
        bus.lzb_en   = lz;
        rst_n        = rn;
        if (!rn) model_reset();
        exp_q.push_back(model_exp());
    endtask

    task automatic idle(input int n, input logic lz);
        repeat (n) drive_cycle(1'b0, 16'($urandom), lz, 1'b1);
    endtask

    function automatic logic [15:0] pick_value();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom);
            1:       return 16'h0040;
            2:       return 16'h0000;
            default: return 16'($urandom) & 16'h00FF;
        endcase
    endfunction

    // Called right after a drive_cycle (posedge + 1): drop reset mid-cycle
    // and check the outputs respond without waiting for a clock edge.
    task automatic async_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_an",    16'(bus.an),      16'h000F);
        chk("rst_ready", 16'(bus.ready),   16'h0001);
        chk("rst_seg",   16'(bus.seg),     16'h007F);
        chk("rst_bin",   16'(bus.bin_out), 16'h0000);
        model_reset();
        exp_q.delete();
        exp_q.push_back(model_exp());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic lz;
        int   guard;
        n_compared   = 0;
        n_mismatched = 0;
        rst_n        = 1'b0;
        bus.load     = 1'b0;
        bus.value_in = '0;
        bus.lzb_en   = 1'b0;
        model_reset();

        repeat (3) drive_cycle(1'b0, 16'h0, 1'b0, 1'b0);
        drive_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        idle(10, 1'b0);

        // Simple load, then load followed by an ignored load.
        drive_cycle(1'b1, 16'h1234, 1'b0, 1'b1);
        idle(70, 1'b0);
        drive_cycle(1'b1, 16'h5678, 1'b0, 1'b1);
        drive_cycle(1'b1, 16'h9999, 1'b0, 1'b1);
        idle(70, 1'b0);

        // Leading-zero blanking.
        drive_cycle(1'b1, 16'h0040, 1'b1, 1'b1);
        idle(70, 1'b1);
        drive_cycle(1'b1, 16'h0000, 1'b1, 1'b1);
        idle(70, 1'b1);

        // Random traffic.
        lz = 1'b0;
        repeat (1500) begin
            if ($urandom_range(0, 31) == 0) lz = ~lz;
            drive_cycle($urandom_range(0, 3) == 0, pick_value(), lz, 1'b1);
        end

        // Reset at slot_cnt 4 of digit 2 while an update is pending.
        guard = 0;
        while (!(m_flag && (m_t % FRAME) == 2 * RD + 4) && guard < 200) begin
            drive_cycle(m_ready, 16'hA5C3 ^ 16'($urandom), 1'b0, 1'b1);
            guard++;
        end
        if (guard >= 200) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL pending_wait: got timeout after %0d cycles expected pending at digit 2 slot 4", guard);
        end else begin
            async_reset_mid();
        end
        repeat (2) drive_cycle(1'b0, 16'h0, 1'b0, 1'b0);
        drive_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        idle(40, 1'b0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
